// File: rtl/multicycle_controller.sv
// Moore control unit for the multicycle ARM-subset datapath: sequencing, NZCV flags, condition check, ALU decode.
// Optional build macro CTRL_MEMWAIT_EN adds MemReady and holds FETCH/MEMRD/MEMWR until memory completes.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
`ifdef CTRL_MEMWAIT_EN
    input  logic       MemReady,
`endif
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
    } state_t;

    typedef struct packed {
        logic       irw, nextpc, regw, memw, branch, aluop, adrsrc, srca;
        logic [1:0] srcb, ressrc;
    } ctl_t;

    // Per-state strobes; registered from the next state so they line up with state_q.
    function automatic ctl_t state_ctl(input state_t s);
        ctl_t c = '0;
        case (s)
            FETCH:  begin c.irw = 1'b1; c.nextpc = 1'b1; c.srca = 1'b1; c.srcb = 2'b10; c.ressrc = 2'b10; end
            DECODE: begin c.srca = 1'b1; c.srcb = 2'b10; c.ressrc = 2'b10; end
            MEMADR: c.srcb = 2'b01;
            MEMRD:  c.adrsrc = 1'b1;
            MEMWB:  begin c.ressrc = 2'b01; c.regw = 1'b1; end
            MEMWR:  begin c.adrsrc = 1'b1; c.memw = 1'b1; end
            EXECR:  c.aluop = 1'b1;
            EXECI:  begin c.srcb = 2'b01; c.aluop = 1'b1; end
            ALUWB:  c.regw = 1'b1;
            BRANCH: begin c.srcb = 2'b01; c.ressrc = 2'b10; c.branch = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t     state_q, state_d;
    ctl_t       ctl_q;
    logic [3:0] flags_q, flags_d;
    logic       condexr_q;
    logic       condex, memrdy, rd15;
    logic [1:0] flagw;
    logic [3:0] cmd;

`ifdef CTRL_MEMWAIT_EN
    assign memrdy = MemReady;
`else
    assign memrdy = 1'b1;
`endif

    assign cmd  = Funct[4:1];
    assign rd15 = (Rd == 4'd15);

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  if (memrdy) state_d = DECODE;
            DECODE: case (Op)
                        2'b01:   state_d = MEMADR;
                        2'b00:   state_d = Funct[5] ? EXECI : EXECR;
                        2'b10:   state_d = BRANCH;
                        default: state_d = FETCH;
                    endcase
            MEMADR: state_d = Funct[0] ? MEMRD : MEMWR;
            MEMRD:  if (memrdy) state_d = MEMWB;
            MEMWR:  if (memrdy) state_d = FETCH;
            EXECR, EXECI: state_d = ALUWB;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        ALUControl = 2'b00;
        if (ctl_q.aluop) begin
            case (cmd)
                4'b0100: ALUControl = 2'b00;
                4'b0010: ALUControl = 2'b01;
                4'b0000: ALUControl = 2'b10;
                default: ALUControl = 2'b11;
            endcase
        end
        flagw = 2'b00;
        if (ctl_q.aluop && Funct[0])
            flagw = (cmd == 4'b0100 || cmd == 4'b0010) ? 2'b11 : 2'b10;
    end

    // flags_q = {N, Z, C, V}
    always_comb begin
        flags_d = flags_q;
        if (condexr_q) begin
            if (flagw[1]) flags_d[3:2] = ALUFlags[3:2];
            if (flagw[0]) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    always_comb begin
        case (Cond)
            4'b0000: condex = flags_q[2];
            4'b0001: condex = ~flags_q[2];
            4'b0010: condex = flags_q[1];
            4'b0011: condex = ~flags_q[1];
            4'b0100: condex = flags_q[3];
            4'b0101: condex = ~flags_q[3];
            4'b0110: condex = flags_q[0];
            4'b0111: condex = ~flags_q[0];
            4'b1000: condex = flags_q[1] & ~flags_q[2];
            4'b1001: condex = ~flags_q[1] | flags_q[2];
            4'b1010: condex = (flags_q[3] == flags_q[0]);
            4'b1011: condex = (flags_q[3] != flags_q[0]);
            4'b1100: condex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: condex = flags_q[2] | (flags_q[3] != flags_q[0]);
            default: condex = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            ctl_q     <= state_ctl(FETCH);
            flags_q   <= 4'b0000;
            condexr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctl_q   <= state_ctl(state_d);
            flags_q <= flags_d;
            if (state_q == DECODE) condexr_q <= condex;
        end
    end

    assign AdrSrc    = ctl_q.adrsrc;
    assign ALUSrcA   = ctl_q.srca;
    assign ALUSrcB   = ctl_q.srcb;
    assign ResultSrc = ctl_q.ressrc;
    // Enables are forced low while reset is held so an aborted instruction cannot write.
    assign IRWrite   = ~reset & ctl_q.irw & memrdy;
    assign MemWrite  = ~reset & ctl_q.memw & condexr_q;
    assign RegWrite  = ~reset & ctl_q.regw & condexr_q & ~rd15;
    assign PCWrite   = ~reset & ((ctl_q.nextpc & memrdy) | (ctl_q.branch & condexr_q) |
                                 (ctl_q.regw & condexr_q & rd15));
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller; per-instruction output traces checked by cycle.
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond, Rd, ALUFlags;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ALUControl;
`ifdef CTRL_MEMWAIT_EN
    logic       MemReady = 1'b1;
`endif

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd), .ALUFlags(ALUFlags),
`ifdef CTRL_MEMWAIT_EN
        .MemReady(MemReady),
`endif
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ALUControl(ALUControl)
    );

    // [11]PCW [10]MemW [9]RegW [8]IRW [7]AdrSrc [6]SrcA [5:4]SrcB [3:2]ResSrc [1:0]ALUCtl
    logic [11:0] ob;
    assign ob = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl};

    int          errs = 0, nchk = 0;
    logic [11:0] tr [0:15];
    int          len;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts in FETCH at a negedge; records one output word per cycle until the next FETCH.
    task automatic run(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                       input logic [3:0] r, input logic [3:0] af);
        Cond = c; Op = o; Funct = f; Rd = r; ALUFlags = af;
        len = 0;
        #1;
        for (int i = 0; i < 16; i++) begin
            tr[i] = ob;
            if (i > 0 && IRWrite) begin
                len = i;
                break;
            end
            @(posedge clk); @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; Cond = 4'hE; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
        @(negedge clk); @(negedge clk);
        chk("rst_outputs", ob, 12'h068);
        reset = 1'b0; #1;
        chk("rst_fetch_irw_pcw", {IRWrite, PCWrite}, 2'b11);

        // SUBS, flags <- 0110
        run(4'hE, 2'b00, 6'b000101, 4'd1, 4'b0110);
        chk("subs_len", len, 4);
        chk("subs_aluctl", tr[2][1:0], 2'b01);
        chk("subs_srcb", tr[2][5:4], 2'b00);
        chk("subs_wb", {tr[3][11], tr[3][9], tr[3][3:2]}, 4'b0100);

        run(4'h1, 2'b10, 6'd0, 4'd0, 4'd0);
        chk("bne_len", len, 3);
        chk("bne_pcw", tr[2][11], 1'b0);
        run(4'h0, 2'b10, 6'd0, 4'd0, 4'd0);
        chk("beq_len", len, 3);
        chk("beq_pcw", tr[2][11], 1'b1);
        chk("beq_sel", {tr[2][5:4], tr[2][3:2]}, 4'b0110);

        run(4'hE, 2'b01, 6'b011001, 4'd3, 4'd0);
        chk("ldr_len", len, 5);
        chk("ldr_memadr", {tr[2][5:4], tr[2][1:0]}, 4'b0100);
        chk("ldr_memrd_adr", tr[3][7], 1'b1);
        chk("ldr_memwb", {tr[4][11], tr[4][9], tr[4][3:2]}, 4'b0101);

        run(4'hE, 2'b01, 6'b011000, 4'd3, 4'd0);
        chk("str_len", len, 4);
        chk("str_memwr", {tr[3][10], tr[3][7], tr[3][9]}, 3'b110);

        run(4'hE, 2'b00, 6'b001000, 4'd15, 4'b1111);
        chk("addpc_len", len, 4);
        chk("addpc_aluctl", tr[2][1:0], 2'b00);
        chk("addpc_wb", {tr[3][11], tr[3][9]}, 2'b10);

        run(4'hE, 2'b11, 6'd0, 4'd0, 4'd0);
        chk("nop_len", len, 2);

        // Z=1 so NE fails: no PC or register write
        run(4'h1, 2'b00, 6'b001000, 4'd15, 4'd0);
        chk("addne_wb", {tr[3][11], tr[3][9]}, 2'b00);

        run(4'hE, 2'b00, 6'b111000, 4'd2, 4'd0);
        chk("orri_exec", {tr[2][5:4], tr[2][1:0]}, 4'b0111);

        // flags 0100, then ANDS with ALUFlags 1011 -> 1000
        run(4'hE, 2'b00, 6'b000101, 4'd1, 4'b0100);
        run(4'hE, 2'b00, 6'b000001, 4'd1, 4'b1011);
        chk("ands_aluctl", tr[2][1:0], 2'b10);
        run(4'h4, 2'b10, 6'd0, 4'd0, 4'd0);
        chk("bmi_after_ands", tr[2][11], 1'b1);
        run(4'h0, 2'b10, 6'd0, 4'd0, 4'd0);
        chk("beq_after_ands", tr[2][11], 1'b0);
        run(4'h2, 2'b10, 6'd0, 4'd0, 4'd0);
        chk("bcs_after_ands", tr[2][11], 1'b0);
        run(4'h6, 2'b10, 6'd0, 4'd0, 4'd0);
        chk("bvs_after_ands", tr[2][11], 1'b0);
        run(4'hB, 2'b10, 6'd0, 4'd0, 4'd0);
        chk("blt_after_ands", tr[2][11], 1'b1);
        run(4'hA, 2'b10, 6'd0, 4'd0, 4'd0);
        chk("bge_after_ands", tr[2][11], 1'b0);

        // Abort a flag-setting SUBS in EXECR
        Cond = 4'hE; Op = 2'b00; Funct = 6'b000101; Rd = 4'd2; ALUFlags = 4'b1111;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        reset = 1'b1; #1;
        chk("rstmid_we_now", ob[11:8], 4'b0000);
        @(posedge clk); @(negedge clk);
        chk("rstmid_we_held", ob[11:8], 4'b0000);
        reset = 1'b0; #1;
        chk("rstmid_fetch", {IRWrite, PCWrite, RegWrite}, 3'b110);
        run(4'h1, 2'b10, 6'd0, 4'd0, 4'd0);
        chk("bne_after_rst", tr[2][11], 1'b1);
        run(4'h2, 2'b10, 6'd0, 4'd0, 4'd0);
        chk("bcs_after_rst", tr[2][11], 1'b0);

`ifdef CTRL_MEMWAIT_EN
        begin
            int mw = 0;
            MemReady = 1'b0; #1;
            chk("wait_fetch_irw", IRWrite, 1'b0);
            MemReady = 1'b1;
            Cond = 4'hE; Op = 2'b01; Funct = 6'b011000; Rd = 4'd3;
            @(posedge clk); @(negedge clk);
            @(posedge clk); @(negedge clk);
            MemReady = 1'b0;
            @(posedge clk); @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (i == 3) MemReady = 1'b1;
                #1;
                if (MemWrite) mw++;
                @(posedge clk); @(negedge clk);
            end
            chk("wait_str_memw_cycles", mw, 4);
            chk("wait_str_fetch", IRWrite, 1'b1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle ARM-subset processor. It sequences the shared datapath (one memory port, one ALU, register file, PC/IR registers) across FETCH/DECODE/EXECUTE/WRITEBACK steps with a Moore state machine. It owns the NZCV flag register, conditional-execution evaluation, and ALU operation/flag-write decoding, and drives every datapath enable and mux select.

## Interface
Parameters: none.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- Cond  in  4  instruction condition field, IR[31:28]
- Op  in  2  IR[27:26]
- Funct  in  6  IR[25:20]; Funct[5]=I, Funct[4:1]=cmd, Funct[0]=S (L for memory)
- Rd  in  4  IR[15:12]
- ALUFlags  in  4  NZCV from ALU, current cycle
- PCWrite, MemWrite, RegWrite, IRWrite  out  1  datapath write enables
- AdrSrc  out  1  0=PC, 1=ALU result register
- ALUSrcA  out  1  0=register A, 1=PC
- ALUSrcB  out  2  00=register B, 01=extended immediate, 10=constant 4
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALU result direct
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR

## Operation
- States (4-bit): FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- FETCH→DECODE. DECODE: Op=01→MEMADR; Op=00,Funct[5]=0→EXECR; Op=00,Funct[5]=1→EXECI; Op=10→BRANCH; Op=11→FETCH (no-op). MEMADR: Funct[0]=1→MEMRD else MEMWR. MEMRD→MEMWB→FETCH. MEMWR→FETCH. EXECR/EXECI→ALUWB→FETCH. BRANCH→FETCH.
- Per-state outputs (unlisted selects 0, unlisted internal strobes 0):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, NextPC=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01, ALU add.
  - MEMRD: AdrSrc=1. MEMWB: ResultSrc=01, RegW=1. MEMWR: AdrSrc=1, MemW=1.
  - EXECR: ALUSrcB=00, ALUOp=1. EXECI: ALUSrcB=01, ALUOp=1. ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode: ALUOp=0→ALUControl=00. ALUOp=1: cmd 0100→00, 0010→01, 0000→10, anything else→11.
- FlagW[1:0] (internal): ALUOp=1 and S=1: ADD/SUB→11, other cmd→10; otherwise 00. FlagW[1] loads N,Z; FlagW[0] loads C,V.
- CondEx from Cond and stored flags: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), 1110/1111 true.
- CondExR registered at end of DECODE; gates all later states of that instruction.
- RegWrite=RegW&CondExR&(Rd!=15). MemWrite=MemW&CondExR. PCWrite=NextPC | (Branch&CondExR) | (RegW&CondExR&Rd==15).
- Flags load ALUFlags per FlagW at end of EXECR/EXECI only, when CondExR=1.

## Timing
- Reset: state=FETCH, flags=0000, CondExR=0; all write enables 0 while reset high; selects take FETCH values.
- Latency: branch 3 cycles, data-processing 4, STR 4, LDR 5, Op=11 2.
- Flag updates are visible to the next instruction's DECODE; ALUWB of the setting instruction uses CondExR, so it is unaffected.
- Reset asserted mid-instruction aborts it: no further writes; FETCH on first edge after deassertion.

## Configuration
- CTRL_MEMWAIT_EN defined: adds input MemReady (1 bit). FETCH, MEMRD and MEMWR hold state until MemReady=1. IRWrite and PCWrite in FETCH assert only in the MemReady=1 cycle. MemWrite stays asserted through the MEMWR wait.
- Undefined: no MemReady port; memory always completes in one cycle.

## Test plan
- Reset mid-EXECR then release → state FETCH, flags 0000, no RegWrite pulse; next cycle IRWrite=1, PCWrite=1.
- SUBS (Op=00, Funct=000101, Cond=1110), ALUFlags=0110 → ALUControl=01 in EXECR, flags=0110 after, RegWrite=1 in ALUWB, total 4 cycles.
- With Z=1, BNE (Op=10, Cond=0001) → PCWrite=0 in BRANCH; BEQ → PCWrite=1; each 3 cycles.
- LDR (Op=01, Funct[0]=1, Rd=3) → MEMADR, MEMRD with AdrSrc=1, MEMWB with ResultSrc=01 and RegWrite=1, 5 cycles. ADD with Rd=15 → PCWrite=1, RegWrite=0 in ALUWB.
- ANDS (cmd 0000, S=1), ALUFlags=1011, prior flags 0100 → flags=1000 (C,V kept).
- CTRL_MEMWAIT_EN: STR with MemReady low 3 cycles in MEMWR → MemWrite high 4 cycles, FETCH follows.
